// File: rtl/fetch_pkg.sv
`default_nettype none
// =============================================================================
// fetch_pkg : shared types and helpers for the instruction fetch stage
// Revision  : 1.0
// =============================================================================
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_ZERO = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
        logic            fault;
    } fetch_entry_t;

    // Pointer width for a power-of-two queue; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// =============================================================================
// fetch_queue : circular buffer of fetch entries with alloc/fill/pop/flush
// Revision    : 1.0
// =============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = ptr_width(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_i,
    input  logic [XLEN-1:0]  alloc_pc_i,
    input  logic             alloc_fault_i,
    input  logic             fill_i,
    input  logic [XLEN-1:0]  fill_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] occ_o,
    output logic [CNT_W-1:0] unfilled_o
);

    fetch_entry_t     ent_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic [CNT_W-1:0] unfilled;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] idx;
    logic             fill_found;

    // Walk live entries oldest-first: the first unfilled one takes the next response.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        unfilled   = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < occ_q) && !ent_q[idx].filled) begin
                unfilled = unfilled + CNT_W'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_idx   = idx;
                end
            end
        end
    end

    assign occ_d = occ_q + CNT_W'(alloc_i) - CNT_W'(pop_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (alloc_i) begin
                ent_q[wr_ptr_q] <= '{pc: alloc_pc_i, instr: INSTR_ZERO,
                                     filled: alloc_fault_i, fault: alloc_fault_i};
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fill_i && fill_found) begin
                ent_q[fill_idx].instr  <= fill_data_i;
                ent_q[fill_idx].filled <= 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_d;
        end
    end

    assign head_o     = ent_q[rd_ptr_q];
    assign occ_o      = occ_q;
    assign unfilled_o = unfilled;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// fetch_unit : in-order instruction fetch with credit flow and redirect flush
// Revision   : 1.0
// =============================================================================
module fetch_unit
    import fetch_pkg::fetch_entry_t, fetch_pkg::ptr_width;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            redirect,
    output logic            pc_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault,
    output logic            protocol_err
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_entry_t     head;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] unfilled;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic             protocol_err_q;
    logic [CNT_W:0]   committed;
    logic             credit;
    logic             misaligned;
    logic             fetch_ok;
    logic             alloc;
    logic             pop;
    logic             outstanding;
    logic             rsp_consumed;
    logic             fill;

    // Wrong-path responses still in flight hold their slot until they drain.
    assign committed  = {1'b0, occ} + {1'b0, drop_cnt_q};
    assign credit     = committed < DEPTH_C;
    assign misaligned = pc_in[1:0] != 2'b00;
    assign fetch_ok   = rst & credit & ~redirect;

    assign imem_req_valid = fetch_ok & ~misaligned;
    assign imem_req_addr  = pc_in;
    assign alloc          = fetch_ok & (misaligned | imem_req_ready);
    assign pc_stall       = ~rst | ~(redirect | alloc);

    assign if_valid = rst & head.filled & (occ != '0) & ~redirect;
    assign pop      = if_valid & if_ready;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;
    assign if_fault = head.fault;

    assign outstanding  = (unfilled != '0) | (drop_cnt_q != '0);
    assign rsp_consumed = imem_rsp_valid & outstanding;
    assign fill         = imem_rsp_valid & (drop_cnt_q == '0) & (unfilled != '0) & ~redirect;

    // A response landing in the redirect cycle already retires one of the flushed fetches.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = drop_cnt_q + unfilled - CNT_W'(rsp_consumed);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q     <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            protocol_err_q <= protocol_err_q | (imem_rsp_valid & ~outstanding);
        end
    end

    assign protocol_err = protocol_err_q;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (alloc),
        .alloc_pc_i    (pc_in),
        .alloc_fault_i (misaligned),
        .fill_i        (fill),
        .fill_data_i   (imem_rsp_data),
        .pop_i         (pop),
        .flush_i       (redirect),
        .head_o        (head),
        .occ_o         (occ),
        .unfilled_o    (unfilled)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// tb_fetch_unit : self-checking bench for fetch_unit (DEPTH=2, latency model)
// Revision      : 1.0
// =============================================================================
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int NV    = 17;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [XLEN-1:0] pc_in = '0;
    logic            redirect = 1'b0;
    logic            pc_stall;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b1;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data = '0;
    logic            if_valid;
    logic            if_ready = 1'b1;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_fault;
    logic            protocol_err;

    fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .redirect       (redirect),
        .pc_stall       (pc_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } mem_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;
    typedef struct {
        logic rst_before; logic rdy; logic exp_req; logic exp_stall; logic exp_valid; logic [31:0] exp_pc;
    } vec_t;

    mem_t        mem_q[$];
    exp_t        sb[$];
    vec_t        vec[NV];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pc_model = '0;
    logic [31:0] target = '0;
    logic [31:0] pop_pc = '0;
    logic [31:0] first_pc;
    logic        redir = 1'b0;
    logic        mem_rdy = 1'b1;
    logic        dec_rdy = 1'b1;
    logic        force_rsp = 1'b0;
    logic        popped = 1'b0;
    logic        got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle's inputs, then observe handshakes before the next rising edge.
    task automatic ds();
        exp_t e;
        logic from_mem;
        from_mem       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            from_mem       = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
        end else if (force_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEADBEEF;
        end
        pc_in          = pc_model;
        redirect       = redir;
        imem_req_ready = mem_rdy;
        if_ready       = dec_rdy;
        #1;
        popped = 1'b0;
        if (from_mem) void'(mem_q.pop_front());
        if (imem_req_valid) chk("req_addr", imem_req_addr, pc_in);
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{32'h13 + pc_in, cyc + lat});
            sb.push_back('{pc_in, 32'h13 + pc_in, 1'b0});
        end else if (pc_in[1:0] != 2'b00 && !pc_stall && !redirect) begin
            sb.push_back('{pc_in, 32'h0, 1'b1});
        end
        if (if_valid && if_ready) begin
            popped = 1'b1;
            pop_pc = if_pc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc 0x%08h expected no entry (cycle %0d)", if_pc, cyc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", if_pc, e.pc);
                chk("pop_instr", if_instr, e.instr);
                chk("pop_fault", {31'b0, if_fault}, {31'b0, e.fault});
            end
        end
        if (redirect) sb.delete();
    endtask

    // Bench-side PC register, then advance to the next cycle.
    task automatic fc();
        if (redirect) pc_model = target;
        else if (!pc_stall) pc_model = pc_model + 32'd4;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1'b0;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
        chk("rst_protocol_err", {31'b0, protocol_err}, 32'd0);
        mem_q.delete();
        sb.delete();
        force_rsp      = 1'b0;
        redir          = 1'b0;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        pc_model       = start_pc;
        pc_in          = start_pc;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        // A pop frees its credit only a cycle later, so DEPTH=2 streams 2 of every 3 cycles.
        vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vec[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vec[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        vec[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
        vec[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8};

        lat     = 1;
        mem_rdy = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (vec[i].rst_before) do_reset(32'h0);
            dec_rdy = vec[i].rdy;
            ds();
            chk("tbl_req_valid", {31'b0, imem_req_valid}, {31'b0, vec[i].exp_req});
            chk("tbl_pc_stall", {31'b0, pc_stall}, {31'b0, vec[i].exp_stall});
            chk("tbl_if_valid", {31'b0, if_valid}, {31'b0, vec[i].exp_valid});
            if (vec[i].exp_valid) begin
                chk("tbl_if_pc", if_pc, vec[i].exp_pc);
                chk("tbl_if_instr", if_instr, 32'h13 + vec[i].exp_pc);
            end
            fc();
        end

        // Redirect with two requests still in flight on a 3-cycle memory.
        do_reset(32'h0);
        lat     = 3;
        dec_rdy = 1'b1;
        ds(); chk("redir_c0_req", {31'b0, imem_req_valid}, 32'd1); fc();
        ds(); fc();
        redir  = 1'b1;
        target = 32'h200;
        ds();
        chk("redir_cyc_req", {31'b0, imem_req_valid}, 32'd0);
        chk("redir_cyc_stall", {31'b0, pc_stall}, 32'd0);
        fc();
        redir = 1'b0;
        ds();
        chk("drop_blocks_req", {31'b0, imem_req_valid}, 32'd0);
        chk("drop_blocks_stall", {31'b0, pc_stall}, 32'd1);
        chk("drop_if_valid", {31'b0, if_valid}, 32'd0);
        fc();
        ds(); chk("resume_req", {31'b0, imem_req_valid}, 32'd1); fc();
        got      = 1'b0;
        first_pc = 32'hFFFF_FFFF;
        for (int n = 0; n < 20 && !got; n++) begin
            ds();
            if (popped) begin got = 1'b1; first_pc = pop_pc; end
            fc();
        end
        chk("redir_first_pc", first_pc, 32'h200);
        repeat (4) begin ds(); fc(); end

        // Misaligned PC becomes a fault entry without touching memory.
        do_reset(32'h102);
        lat     = 1;
        dec_rdy = 1'b0;
        ds();
        chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("mis_pc_stall", {31'b0, pc_stall}, 32'd0);
        fc();
        ds();
        chk("mis_if_valid", {31'b0, if_valid}, 32'd1);
        chk("mis_if_fault", {31'b0, if_fault}, 32'd1);
        chk("mis_if_instr", if_instr, 32'h0);
        chk("mis_if_pc", if_pc, 32'h102);
        fc();
        dec_rdy = 1'b1;
        repeat (4) begin ds(); fc(); end

        // Spurious response with nothing outstanding sets a sticky error.
        do_reset(32'h0);
        mem_rdy = 1'b0;
        ds();
        chk("perr_idle", {31'b0, protocol_err}, 32'd0);
        chk("perr_no_alloc_stall", {31'b0, pc_stall}, 32'd1);
        fc();
        force_rsp = 1'b1;
        ds(); fc();
        force_rsp = 1'b0;
        ds(); chk("perr_set", {31'b0, protocol_err}, 32'd1); fc();
        repeat (3) begin ds(); fc(); end
        chk("perr_sticky", {31'b0, protocol_err}, 32'd1);
        mem_rdy = 1'b1;

        // Asynchronous reset with entries buffered, then a clean restart.
        do_reset(32'h0);
        dec_rdy = 1'b0;
        repeat (3) begin ds(); fc(); end
        ds();
        chk("pre_rst_if_valid", {31'b0, if_valid}, 32'd1);
        do_reset(32'h0);
        dec_rdy = 1'b1;
        ds();
        chk("restart_req", {31'b0, imem_req_valid}, 32'd1);
        chk("restart_if_valid", {31'b0, if_valid}, 32'd0);
        fc();
        got      = 1'b0;
        first_pc = 32'hFFFF_FFFF;
        for (int n = 0; n < 10 && !got; n++) begin
            ds();
            if (popped) begin got = 1'b1; first_pc = pop_pc; end
            fc();
        end
        chk("restart_first_pc", first_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
